// File: rtl/ps2_rx_frame.sv
// PS/2 receive front-end: synchronise and deglitch the lines, assemble the 11-bit frame, check it.
// Optional PS2_BREAK_FILTER_EN: swallow 0xF0 break prefixes and the released-key code that follows.
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] code,
  output logic [7:0]  scan_code,
  output logic        code_valid,
  output logic        frame_err,
  output logic        timeout_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic                   filt, filt_q, fall;
  logic [FW-1:0]          fcnt;

  state_t        state, state_n;
  logic [10:0]   shreg, shreg_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [10:0]   code_n;
  logic          valid_n, ferr_n, terr_n;
  logic          good;
`ifdef PS2_BREAK_FILTER_EN
  logic          break_pending, break_pending_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // fcnt counts consecutive samples disagreeing with filt; the FILTER_LEN-th one flips it
  always_ff @(posedge clk) begin
    if (reset) begin
      filt   <= 1'b1;
      filt_q <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_q <= filt;
      if (clk_s != filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt <= clk_s;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign fall = filt_q & ~filt;
  assign good = ~shreg[0] & shreg[10] & (^shreg[9:1]);

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    tcnt_n   = tcnt;
    code_n   = code;
    valid_n  = 1'b0;
    ferr_n   = 1'b0;
    terr_n   = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    break_pending_n = break_pending;
`endif
    case (state)
      IDLE: begin
        tcnt_n = '0;
        if (fall && !data_s) begin
          shreg_n  = {data_s, shreg[10:1]};
          bitcnt_n = 4'd1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (fall) begin
          shreg_n  = {data_s, shreg[10:1]};
          bitcnt_n = bitcnt + 4'd1;
          tcnt_n   = '0;
          if (bitcnt == 4'd10) state_n = CHECK;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          terr_n   = 1'b1;
          shreg_n  = '0;
          bitcnt_n = '0;
          tcnt_n   = '0;
          state_n  = IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      CHECK: begin
        state_n  = IDLE;
        bitcnt_n = '0;
        tcnt_n   = '0;
        shreg_n  = '0;
        if (good) begin
`ifdef PS2_BREAK_FILTER_EN
          if (break_pending) begin
            break_pending_n = 1'b0;
          end else if (shreg[8:1] == 8'hF0) begin
            break_pending_n = 1'b1;
          end else begin
            code_n  = shreg;
            valid_n = 1'b1;
          end
`else
          code_n  = shreg;
          valid_n = 1'b1;
`endif
        end else begin
          ferr_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      tcnt        <= '0;
      code        <= '0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bitcnt      <= bitcnt_n;
      tcnt        <= tcnt_n;
      code        <= code_n;
      code_valid  <= valid_n;
      frame_err   <= ferr_n;
      timeout_err <= terr_n;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  always_ff @(posedge clk) begin
    if (reset) break_pending <= 1'b0;
    else       break_pending <= break_pending_n;
  end
`endif

  assign scan_code = code[8:1];

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed plus randomized bench for ps2_rx_frame against a frame-level reference model.
module tb_ps2_rx_frame;

  localparam int S = 2;
  localparam int F = 4;
  localparam int T = 3000;
  localparam int H = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] code;
  logic [7:0]  scan_code;
  logic        code_valid, frame_err, timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_terr = 0;
  int valid_cyc = 0, terr_cyc = 0;

  logic [10:0] m_code = '0;
  logic        m_bp = 1'b0;

  ps2_rx_frame #(.SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .scan_code(scan_code), .code_valid(code_valid),
    .frame_err(frame_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (code_valid)  begin n_valid++; valid_cyc = cyc; end
    if (frame_err)   n_ferr++;
    if (timeout_err) begin n_terr++; terr_cyc = cyc; end
    if (!reset && (code_valid | frame_err | timeout_err))
      chk("onehot_pulses", 32'($countones({code_valid, frame_err, timeout_err}) <= 1), 32'd1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic pflip, input logic stop);
    logic p;
    p = (($countones(b) % 2) == 0) ^ pflip;
    return {stop, p, b, 1'b0};
  endfunction

  task automatic send_range(input logic [10:0] b, input int lo, input int hi, output int last_c);
    last_c = 0;
    for (int i = lo; i <= hi; i++) begin
      ps2_data = b[i];
      tick(H);
      ps2_clk = 1'b0;
      last_c = cyc;
      tick(H);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [10:0] b, input string tag);
    int  c, pv, pf;
    logic ev, ef, g;
    g  = (b[0] == 1'b0) && (b[10] == 1'b1) && (($countones(b[9:1]) % 2) == 1);
    ev = 1'b0;
    ef = !g;
    if (g) begin
`ifdef PS2_BREAK_FILTER_EN
      if (m_bp) m_bp = 1'b0;
      else if (b[8:1] == 8'hF0) m_bp = 1'b1;
      else begin ev = 1'b1; m_code = b; end
`else
      ev = 1'b1;
      m_code = b;
`endif
    end
    pv = n_valid;
    pf = n_ferr;
    send_range(b, 0, 10, c);
    tick(2 * H);
    chk({tag, " valid_count"}, 32'(n_valid - pv), 32'(ev));
    chk({tag, " ferr_count"}, 32'(n_ferr - pf), 32'(ef));
    chk({tag, " code"}, 32'(code), 32'(m_code));
    chk({tag, " scan_code"}, 32'(scan_code), 32'(m_code[8:1]));
    if (ev) chk({tag, " latency"}, 32'(valid_cyc - c), 32'(S + F + 2));
  endtask

  initial begin
    int c, pt, pv;
    int unsigned r;
    logic [10:0] part;

    tick(4);
    chk("reset code", 32'(code), 32'h0);
    chk("reset pulses", 32'({code_valid, frame_err, timeout_err}), 32'h0);
    reset = 1'b0;
    tick(4);
    chk("post_reset code", 32'(code), 32'h0);

    run_frame(mk(8'h1C, 1'b0, 1'b1), "a_1C");
    chk("a_1C literal", 32'(code), 32'h438);

    run_frame(mk(8'h1C, 1'b1, 1'b1), "bad_parity");
    chk("bad_parity literal", 32'(code), 32'h438);

    // partial frame then silence
    pt = n_terr;
    pv = n_valid;
    part = mk(8'h55, 1'b0, 1'b1);
    send_range(part, 0, 4, c);
    for (int i = 0; i < T + 100 && n_terr == pt; i++) tick(1);
    chk("timeout count", 32'(n_terr - pt), 32'd1);
    chk("timeout window", 32'((terr_cyc - c >= T) && (terr_cyc - c <= T + S + F + 4)), 32'd1);
    chk("timeout no_valid", 32'(n_valid - pv), 32'd0);
    run_frame(mk(8'h23, 1'b0, 1'b1), "d_23");
    chk("d_23 literal", 32'(code), 32'h446);

    // sub-filter-length low glitches in idle and mid-frame
    for (int k = 0; k < 3; k++) begin
      ps2_clk = 1'b0; tick(F - 1);
      ps2_clk = 1'b1; tick(8);
    end
    part = mk(8'h24, 1'b0, 1'b1);
    pv = n_valid;
    send_range(part, 0, 3, c);
    ps2_data = part[4];
    tick(3);
    ps2_clk = 1'b0; tick(F - 1);
    ps2_clk = 1'b1; tick(3);
    send_range(part, 4, 10, c);
    tick(2 * H);
    chk("glitch valid_count", 32'(n_valid - pv), 32'd1);
    chk("glitch code", 32'(code), 32'h648);
    m_code = code === 11'h648 ? 11'h648 : m_code;

    // reset mid-frame
    pv = n_valid;
    pt = n_terr + n_ferr;
    send_range(mk(8'h77, 1'b0, 1'b1), 0, 5, c);
    reset = 1'b1; tick(1); reset = 1'b0;
    m_code = '0;
    m_bp = 1'b0;
    tick(2 * H);
    chk("midreset code", 32'(code), 32'h0);
    chk("midreset pulses", 32'((n_valid - pv) + (n_terr + n_ferr - pt)), 32'd0);
    run_frame(mk(8'h2B, 1'b0, 1'b1), "k_2B");
    chk("k_2B literal", 32'(code), 32'h656);

    run_frame(mk(8'hF0, 1'b0, 1'b1), "brk_F0");
    run_frame(mk(8'h1C, 1'b0, 1'b1), "brk_1C");
    run_frame(mk(8'h1C, 1'b0, 1'b1), "make_1C");
    chk("make_1C literal", 32'(code), 32'h438);

    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 3);
      run_frame(mk(8'($urandom), r == 0, r != 1), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed cycle %0d", cyc);
    $fatal(1);
  end

endmodule
